// File: rtl/uart_gpio_pkg.sv
// Shared opcodes, reply bytes, FSM state encoding and reply-load payload for the UART/GPIO bridge.
package uart_gpio_pkg;

    localparam logic [7:0] OP_WR_MODE = 8'h01;
    localparam logic [7:0] OP_WR_DATA = 8'h02;
    localparam logic [7:0] OP_READ    = 8'h03;

    localparam logic [7:0] ACK_BYTE = 8'hAC;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    // Reply serializer byte count: a reply is at most four bytes.
    localparam int unsigned SER_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        APPLY,
        SAMPLE,
        REPLY
    } state_t;

    typedef struct packed {
        logic [31:0]          word;
        logic [SER_CNT_W-1:0] nbytes;
    } reply_cmd_t;

endpackage

// File: rtl/uart_gpio_reply_ser.sv
// Reply serializer: loads a word and byte count, emits bytes LSB first over ready/valid.
module uart_gpio_reply_ser
    import uart_gpio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [31:0]          word,
    input  logic [SER_CNT_W-1:0] nbytes,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 done
);

    logic [31:0]          rest;
    logic [SER_CNT_W-1:0] left;

    // rest holds the bytes not yet presented; done pulses the cycle after the last handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rest     <= '0;
            left     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rest     <= word >> 8;
                left     <= nbytes;
                tx_data  <= word[7:0];
                tx_valid <= (nbytes != '0);
            end else if (tx_valid && tx_ready) begin
                if (left == SER_CNT_W'(1)) begin
                    tx_valid <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    tx_data <= rest[7:0];
                    rest    <= rest >> 8;
                end
                left <= left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_gpio_bridge.sv
// Byte-command bridge: parses RX commands, applies GPIO mode/data words atomically, replies over TX.
module uart_gpio_bridge
    import uart_gpio_pkg::*;
#(
    parameter int unsigned PIN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 60000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [PIN_W-1:0] gpio_mode,
    output logic [PIN_W-1:0] gpio_data,
    output logic             gpio_valid,
    input  logic [PIN_W-1:0] gpio_in,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_opcode,
    output logic             err_overrun
);

    localparam int unsigned NB     = (PIN_W + 7) / 8;
    localparam int unsigned SH_W   = NB * 8;
    localparam int unsigned BCNT_W = $clog2(NB + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    state_t              state;
    state_t              state_next;
    logic                is_mode;
    logic [PIN_W-1:0]    shadow;
    logic [PIN_W-1:0]    shadow_merge_c;
    logic [BCNT_W-1:0]   bcnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                start_c;
    logic                accept_c;
    logic                commit_c;
    logic                tmo_fire_c;
    logic                bad_op_c;
    logic                overrun_c;
    logic                ser_load_c;
    reply_cmd_t          ser_cmd_c;
    logic                ser_done;

    // Incoming payload byte lands at its LSB-first slot; bits above PIN_W fall off
    assign shadow_merge_c = shadow | PIN_W'(SH_W'(rx_data) << {bcnt, 3'b000});

    always_comb begin
        state_next = state;
        start_c    = 1'b0;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        tmo_fire_c = 1'b0;
        bad_op_c   = 1'b0;
        overrun_c  = 1'b0;
        ser_load_c = 1'b0;
        ser_cmd_c  = '0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR_MODE || rx_data == OP_WR_DATA) begin
                        start_c    = 1'b1;
                        state_next = PAYLOAD;
                    end else if (rx_data == OP_READ) begin
                        state_next = SAMPLE;
                    end else begin
                        bad_op_c         = 1'b1;
                        ser_load_c       = 1'b1;
                        ser_cmd_c.word   = 32'(NAK_BYTE);
                        ser_cmd_c.nbytes = SER_CNT_W'(1);
                        state_next       = REPLY;
                    end
                end
            end
            PAYLOAD: begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                if (rx_valid) begin
                    accept_c = 1'b1;
                    if (bcnt == BCNT_W'(NB - 1)) begin
                        commit_c   = 1'b1;
                        state_next = APPLY;
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_fire_c = 1'b1;
                    state_next = IDLE;
                end
            end
            APPLY: begin
                ser_load_c       = 1'b1;
                ser_cmd_c.word   = 32'(ACK_BYTE);
                ser_cmd_c.nbytes = SER_CNT_W'(1);
                state_next       = REPLY;
            end
            SAMPLE: begin
                ser_load_c       = 1'b1;
                ser_cmd_c.word   = 32'(gpio_in);
                ser_cmd_c.nbytes = SER_CNT_W'(NB);
                state_next       = REPLY;
            end
            REPLY: begin
                if (ser_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rx_valid && (state == APPLY || state == SAMPLE || state == REPLY)) begin
            overrun_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            is_mode     <= 1'b0;
            shadow      <= '0;
            bcnt        <= '0;
            tmo_cnt     <= '0;
            gpio_mode   <= '0;
            gpio_data   <= '0;
            gpio_valid  <= 1'b0;
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            gpio_valid  <= commit_c;
            err_timeout <= tmo_fire_c;
            err_opcode  <= bad_op_c;
            err_overrun <= overrun_c;

            if (start_c) begin
                is_mode <= (rx_data == OP_WR_MODE);
                shadow  <= '0;
                bcnt    <= '0;
            end else if (accept_c) begin
                shadow <= shadow_merge_c;
                bcnt   <= bcnt + 1'b1;
            end else if (tmo_fire_c) begin
                shadow <= '0;
                bcnt   <= '0;
            end

            // Idle-cycle counter only runs between payload bytes
            if (rx_valid || state != PAYLOAD) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (commit_c) begin
                if (is_mode) begin
                    gpio_mode <= shadow_merge_c;
                end else begin
                    gpio_data <= shadow_merge_c;
                end
            end
        end
    end

    uart_gpio_reply_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load_c),
        .word     (ser_cmd_c.word),
        .nbytes   (ser_cmd_c.nbytes),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_uart_gpio_bridge.sv
// Bench for uart_gpio_bridge: 16-pin and 12-pin instances driven in lockstep against a command-level model.
module tb_uart_gpio_bridge;

    localparam int unsigned TMO = 40;

    typedef logic [7:0] byteq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [15:0] gpio_in;

    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_tx_valid, b_tx_valid;
    logic [15:0] a_mode, a_data;
    logic [11:0] b_mode, b_data;
    logic        a_gv, b_gv, a_busy, b_busy;
    logic        a_et, b_et, a_eo, b_eo, a_eov, b_eov;

    int total = 0;
    int bad   = 0;

    // Model state: committed words per width, expected pulse counts (gv, timeout, opcode, overrun)
    logic [15:0] m_mode16 = '0, m_data16 = '0;
    logic [11:0] m_mode12 = '0, m_data12 = '0;
    int exp_pulses[4] = '{default: 0};
    int pc_a[4]       = '{default: 0};
    int pc_b[4]       = '{default: 0};

    always #5 clk = ~clk;

    uart_gpio_bridge #(.PIN_W(16), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
        .gpio_mode(a_mode), .gpio_data(a_data), .gpio_valid(a_gv), .gpio_in(gpio_in),
        .busy(a_busy), .err_timeout(a_et), .err_opcode(a_eo), .err_overrun(a_eov)
    );

    uart_gpio_bridge #(.PIN_W(12), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
        .gpio_mode(b_mode), .gpio_data(b_data), .gpio_valid(b_gv), .gpio_in(gpio_in[11:0]),
        .busy(b_busy), .err_timeout(b_et), .err_opcode(b_eo), .err_overrun(b_eov)
    );

    always @(posedge clk) begin
        if (a_gv)  pc_a[0]++;
        if (a_et)  pc_a[1]++;
        if (a_eo)  pc_a[2]++;
        if (a_eov) pc_a[3]++;
        if (b_gv)  pc_b[0]++;
        if (b_et)  pc_b[1]++;
        if (b_eo)  pc_b[2]++;
        if (b_eov) pc_b[3]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_gpio();
        check("mode_a", 32'(a_mode), 32'(m_mode16));
        check("data_a", 32'(a_data), 32'(m_data16));
        check("mode_b", 32'(b_mode), 32'(m_mode12));
        check("data_b", 32'(b_data), 32'(m_data12));
    endtask

    task automatic check_reset_outputs();
        check("rst_mode_a", 32'(a_mode), 0);
        check("rst_data_a", 32'(a_data), 0);
        check("rst_txd_a", 32'(a_tx_data), 0);
        check("rst_txv_a", 32'(a_tx_valid), 0);
        check("rst_gv_a", 32'(a_gv), 0);
        check("rst_busy_a", 32'(a_busy), 0);
        check("rst_err_a", 32'({a_et, a_eo, a_eov}), 0);
        check("rst_mode_b", 32'(b_mode), 0);
        check("rst_data_b", 32'(b_data), 0);
        check("rst_txd_b", 32'(b_tx_data), 0);
        check("rst_txv_b", 32'(b_tx_valid), 0);
        check("rst_busy_b", 32'(b_busy), 0);
        check("rst_err_b", 32'({b_gv, b_et, b_eo, b_eov}), 0);
    endtask

    task automatic check_pulses();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pulses_a%0d", i), 32'(pc_a[i]), 32'(exp_pulses[i]));
            check($sformatf("pulses_b%0d", i), 32'(pc_b[i]), 32'(exp_pulses[i]));
        end
    endtask

    // Reply bytes must be presented back-to-back starting at the current cycle (tx_ready held high)
    task automatic expect_reply(input byteq_t e16, input byteq_t e12);
        for (int k = 0; k < e16.size(); k++) begin
            check($sformatf("txv_a[%0d]", k), 32'(a_tx_valid), 1);
            check($sformatf("txd_a[%0d]", k), 32'(a_tx_data), 32'(e16[k]));
            check($sformatf("txv_b[%0d]", k), 32'(b_tx_valid), 1);
            check($sformatf("txd_b[%0d]", k), 32'(b_tx_data), 32'(e12[k]));
            @(negedge clk);
        end
        check("tx_end_a", 32'(a_tx_valid), 0);
        check("tx_end_b", 32'(b_tx_valid), 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (a_busy || b_busy); i++) @(negedge clk);
        check("idle_a", 32'(a_busy), 0);
        check("idle_b", 32'(b_busy), 0);
    endtask

    // One complete command with tx_ready held high, checked at its exact cycle timing
    task automatic do_cmd(input logic [7:0] op, input logic [15:0] word, input logic [15:0] pins);
        byteq_t e16, e12;
        gpio_in  = pins;
        tx_ready = 1'b1;
        if (op == 8'h01 || op == 8'h02) begin
            send_byte(op);
            send_byte(word[7:0]);
            send_byte(word[15:8]);
            if (op == 8'h01) begin
                m_mode16 = word;
                m_mode12 = 12'(word % 4096);
            end else begin
                m_data16 = word;
                m_data12 = 12'(word % 4096);
            end
            exp_pulses[0]++;
            check("gv_a", 32'(a_gv), 1);
            check("gv_b", 32'(b_gv), 1);
            check("wr_txv_early", 32'(a_tx_valid), 0);
            check_gpio();
            @(negedge clk);
            e16.push_back(8'hAC);
            e12.push_back(8'hAC);
        end else if (op == 8'h03) begin
            send_byte(op);
            check("rd_txv_early", 32'(a_tx_valid), 0);
            check("rd_busy", 32'(a_busy), 1);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e16.push_back(8'(pins >> (8 * i)));
                e12.push_back(8'((pins % 4096) >> (8 * i)));
            end
        end else begin
            send_byte(op);
            exp_pulses[2]++;
            check("err_op_a", 32'(a_eo), 1);
            check("err_op_b", 32'(b_eo), 1);
            e16.push_back(8'hEE);
            e12.push_back(8'hEE);
        end
        expect_reply(e16, e12);
        wait_idle();
        check_gpio();
        check_pulses();
    endtask

    initial begin
        int unsigned sel;
        logic [7:0]  op;
        logic [15:0] w, p;
        byteq_t      q16, q12;

        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        gpio_in  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Directed basics: mode write, data write, readback
        do_cmd(8'h01, 16'h1234, 16'h0000);
        do_cmd(8'h02, 16'h00FF, 16'h0000);
        do_cmd(8'h03, 16'h0000, 16'hBEEF);

        // Partial command abandoned: timeout fires exactly TMO cycles after the last byte
        tx_ready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h55);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_early_a", 32'(a_et), 0);
        check("tmo_busy_a", 32'(a_busy), 1);
        @(negedge clk);
        exp_pulses[1]++;
        check("tmo_a", 32'(a_et), 1);
        check("tmo_b", 32'(b_et), 1);
        check("tmo_idle_a", 32'(a_busy), 0);
        repeat (3) @(negedge clk);
        check("tmo_no_tx", 32'(a_tx_valid | b_tx_valid), 0);
        check_gpio();
        check_pulses();
        do_cmd(8'h03, 16'h0000, 16'h5AC3);

        // Byte arriving on the expiry cycle is accepted
        send_byte(8'h02);
        send_byte(8'h3C);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'hA5);
        m_data16 = 16'hA53C;
        m_data12 = 12'h53C;
        exp_pulses[0]++;
        check("race_no_tmo", 32'(a_et), 0);
        check("race_gv", 32'(a_gv), 1);
        check_gpio();
        @(negedge clk);
        q16 = '{8'hAC};
        q12 = '{8'hAC};
        expect_reply(q16, q12);
        wait_idle();
        check_pulses();

        // Unknown opcode with a stalled transmitter: NAK held
        tx_ready = 1'b0;
        send_byte(8'h7A);
        exp_pulses[2]++;
        check("nak_eo", 32'(a_eo), 1);
        for (int i = 0; i < 10; i++) begin
            check("nak_hold_v", 32'(a_tx_valid & b_tx_valid), 1);
            check("nak_hold_d", 32'(a_tx_data), 32'(8'hEE));
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("nak_done", 32'(a_tx_valid), 0);
        wait_idle();
        check_pulses();

        // Byte arriving during a stalled READ reply is dropped with an overrun pulse
        tx_ready = 1'b0;
        gpio_in  = 16'h1357;
        send_byte(8'h03);
        @(negedge clk);
        check("ovr_txv", 32'(a_tx_valid), 1);
        send_byte(8'h02);
        exp_pulses[3]++;
        check("ovr_a", 32'(a_eov), 1);
        check("ovr_b", 32'(b_eov), 1);
        check("ovr_busy", 32'(a_busy), 1);
        tx_ready = 1'b1;
        q16 = '{8'h57, 8'h13};
        q12 = '{8'h57, 8'h03};
        expect_reply(q16, q12);
        wait_idle();
        check_gpio();
        check_pulses();

        // Masking of bits above the pin count
        do_cmd(8'h01, 16'hFCAB, 16'h0000);
        do_cmd(8'h03, 16'h0000, 16'hFFFF);

        // Randomized command mix
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                default: op = 8'($urandom_range(4, 255));
            endcase
            w = 16'($urandom);
            p = 16'($urandom);
            do_cmd(op, w, p);
        end

        // Reset mid-payload returns every output to its reset value
        do_cmd(8'h01, 16'hF00F, 16'h0000);
        do_cmd(8'h02, 16'h0FF0, 16'h0000);
        send_byte(8'h01);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_mode16 = '0;
        m_data16 = '0;
        m_mode12 = '0;
        m_data12 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset with a pending reply discards it (error pulse cleared before any clock edge)
        tx_ready = 1'b0;
        send_byte(8'h7A);
        check("pend_txv", 32'(a_tx_valid), 1);
        rst_n = 1'b0;
        #1;
        check("pend_drop_a", 32'(a_tx_valid), 0);
        check("pend_drop_b", 32'(b_tx_valid), 0);
        check("pend_busy", 32'(a_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("post_rst_txv", 32'(a_tx_valid), 0);
        do_cmd(8'h02, 16'h6D2B, 16'h0000);
        do_cmd(8'h03, 16'h0000, 16'h8421);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
